ik_phase_sequencer: RTL and testbench

Parametrised phase sequencer that replaces the hard-coded 113-cycle count loop driving the full-Jacobian datapath.
- Generates the phase counter plus NUM_STROBES programmable one-cycle strobes, such as the mat_mult clear pulses.
- Generates NUM_WINDOWS programmable half-open mode windows, such as the mat_mode select.
- Adds a start/done handshake, a programmable iteration limit and a continuous mode.
- Sits between the host-facing control registers and the full_jacobian/mat_mult/array_mult instances.

---
 rtl/ik_seq_pkg.sv | 10 +
 rtl/ik_seq_cmp.sv | 17 +
 rtl/ik_phase_sequencer.sv | 157 +++++++++++++++
 tb/tb_ik_phase_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ik_seq_pkg.sv
// Shared types and default sizing for the phase sequencer.
package ik_seq_pkg;

    typedef enum logic {IDLE, RUN} seq_state_t;

    localparam int PERIOD_DEF = 113;
    localparam int CNT_W_DEF  = 8;
    localparam int ITER_W_DEF = 16;

endpackage

// File: rtl/ik_seq_cmp.sv
// Half-open range comparator slice: hit when lo <= count < hi.
// A strobe is the one-wide range [pos, pos+1); a window uses [lo, hi) directly.
module ik_seq_cmp #(
    parameter int CNT_W = 8
) (
    input  logic [CNT_W-1:0] count_i,
    input  logic [CNT_W:0]   lo_i,
    input  logic [CNT_W:0]   hi_i,
    output logic             hit_o
);

    logic [CNT_W:0] cnt_ext;

    assign cnt_ext = {1'b0, count_i};
    assign hit_o   = (cnt_ext >= lo_i) && (cnt_ext < hi_i);

endmodule

// File: rtl/ik_phase_sequencer.sv
// Phase sequencer: counter, programmable strobes/windows, start/done handshake.
// Optional stall monitor output stall_cycles when IK_SEQ_STALL_MON_EN is defined.
module ik_phase_sequencer
    import ik_seq_pkg::*;
#(
    parameter int PERIOD      = PERIOD_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int NUM_STROBES = 2,
    parameter int NUM_WINDOWS = 1,
    parameter int ITER_W      = ITER_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         continuous,
    input  logic [ITER_W-1:0]            max_iter,
    input  logic [NUM_STROBES*CNT_W-1:0] strobe_pos,
    input  logic [NUM_WINDOWS*CNT_W-1:0] win_lo,
    input  logic [NUM_WINDOWS*CNT_W-1:0] win_hi,
    output logic [CNT_W-1:0]             count,
    output logic [ITER_W-1:0]            iter,
    output logic [NUM_STROBES-1:0]       strobe,
    output logic [NUM_WINDOWS-1:0]       window,
    output logic                         busy,
    output logic                         done
`ifdef IK_SEQ_STALL_MON_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    seq_state_t              state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic [ITER_W-1:0]       max_q, max_d;
    logic                    cont_q, cont_d;
    logic                    done_q, done_d;
    logic [NUM_STROBES-1:0]  strobe_q, strobe_d;
    logic [NUM_STROBES-1:0]  strobe_hit;
    logic [NUM_WINDOWS-1:0]  win_hit;
    logic [ITER_W:0]         iter_inc;
    logic                    accept;
    logic                    last_period;

    for (genvar i = 0; i < NUM_STROBES; i++) begin : g_strobe
        ik_seq_cmp #(.CNT_W(CNT_W)) u_cmp (
            .count_i (count_q),
            .lo_i    ({1'b0, strobe_pos[i*CNT_W +: CNT_W]}),
            .hi_i    ({1'b0, strobe_pos[i*CNT_W +: CNT_W]} + (CNT_W+1)'(1)),
            .hit_o   (strobe_hit[i])
        );
    end

    for (genvar j = 0; j < NUM_WINDOWS; j++) begin : g_window
        ik_seq_cmp #(.CNT_W(CNT_W)) u_cmp (
            .count_i (count_q),
            .lo_i    ({1'b0, win_lo[j*CNT_W +: CNT_W]}),
            .hi_i    ({1'b0, win_hi[j*CNT_W +: CNT_W]}),
            .hit_o   (win_hit[j])
        );
    end

    assign accept      = (state_q == IDLE) && start && en && !abort;
    // One bit wider so a saturated iter can never alias the latched limit.
    assign iter_inc    = {1'b0, iter_q} + (ITER_W+1)'(1);
    assign last_period = !cont_q && (iter_inc == {1'b0, max_q});

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        iter_d   = iter_q;
        max_d    = max_q;
        cont_d   = cont_q;
        done_d   = 1'b0;
        strobe_d = (state_q == RUN && en) ? strobe_hit : '0;

        if (abort) begin
            state_d  = IDLE;
            count_d  = '0;
            strobe_d = '0;
        end else if (accept) begin
            state_d = RUN;
            count_d = '0;
            iter_d  = '0;
            cont_d  = continuous;
            max_d   = (max_iter == '0) ? ITER_W'(1) : max_iter;
        end else if (state_q == RUN && en) begin
            if (count_q == LAST) begin
                count_d = '0;
                if (!(&iter_q)) begin
                    iter_d = iter_q + ITER_W'(1);
                end
                if (last_period) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            iter_q   <= '0;
            max_q    <= ITER_W'(1);
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            iter_q   <= iter_d;
            max_q    <= max_d;
            cont_q   <= cont_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign count  = count_q;
    assign iter   = iter_q;
    assign strobe = strobe_q;
    assign done   = done_q;
    assign window = busy ? win_hit : '0;

`ifdef IK_SEQ_STALL_MON_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (accept) begin
            stall_d = '0;
        end else if (busy && !en && !(&stall_q)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ik_phase_sequencer.sv
// Self-checking bench for ik_phase_sequencer: directed scenarios plus random traffic vs. a behavioural model.
module tb_ik_phase_sequencer;

    localparam int PERIOD = 113;
    localparam int CNT_W  = 8;
    localparam int NS     = 2;
    localparam int NW     = 1;
    localparam int ITER_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n, en, start, abort, continuous;
    logic [ITER_W-1:0]    max_iter;
    logic [NS*CNT_W-1:0]  strobe_pos;
    logic [NW*CNT_W-1:0]  win_lo, win_hi;
    logic [CNT_W-1:0]     count;
    logic [ITER_W-1:0]    iter;
    logic [NS-1:0]        strobe;
    logic [NW-1:0]        window;
    logic                 busy, done;
`ifdef IK_SEQ_STALL_MON_EN
    logic [31:0]          stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;

    // Reference model state, plain integers.
    bit          m_run;
    int          m_count, m_periods, m_limit;
    bit          m_cont, m_done;
    logic [NS-1:0] m_strobe;
    longint      m_stall;

    always #5 clk = ~clk;

    ik_phase_sequencer #(
        .PERIOD(PERIOD), .CNT_W(CNT_W), .NUM_STROBES(NS), .NUM_WINDOWS(NW), .ITER_W(ITER_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .abort(abort),
        .continuous(continuous), .max_iter(max_iter), .strobe_pos(strobe_pos),
        .win_lo(win_lo), .win_hi(win_hi), .count(count), .iter(iter),
        .strobe(strobe), .window(window), .busy(busy), .done(done)
`ifdef IK_SEQ_STALL_MON_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_count = 0; m_periods = 0; m_limit = 1;
        m_cont = 0; m_done = 0; m_strobe = '0; m_stall = 0;
    endtask

    task automatic model_step();
        logic [NS-1:0] s_n;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NS; i++)
            s_n[i] = m_run && en && (m_count == int'(strobe_pos[i*CNT_W +: CNT_W]));
        if (m_run && !en && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_done = 0;
        if (abort) begin
            m_run = 0; m_count = 0; s_n = '0;
        end else if (!m_run && start && en) begin
            m_run = 1; m_count = 0; m_periods = 0; m_cont = continuous;
            m_limit = (max_iter == 0) ? 1 : int'(max_iter);
            m_stall = 0;
        end else if (m_run && en) begin
            if (m_count == PERIOD - 1) begin
                m_count = 0;
                m_periods++;
                if (!m_cont && m_periods == m_limit) begin
                    m_run = 0; m_done = 1;
                end
            end else begin
                m_count++;
            end
        end
        m_strobe = s_n;
    endtask

    task automatic compare_all();
        logic [NW-1:0] w;
        int lo, hi;
        for (int j = 0; j < NW; j++) begin
            lo = int'(win_lo[j*CNT_W +: CNT_W]);
            hi = int'(win_hi[j*CNT_W +: CNT_W]);
            w[j] = m_run && (m_count >= lo) && (m_count < hi);
        end
        check("count",  count,  m_count);
        check("iter",   iter,   (m_periods > 65535) ? 65535 : m_periods);
        check("strobe", strobe, m_strobe);
        check("window", window, w);
        check("busy",   busy,   m_run);
        check("done",   done,   m_done);
`ifdef IK_SEQ_STALL_MON_EN
        check("stall",  stall_cycles, m_stall);
`endif
        if (done === 1'b1) done_seen++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to_count(input int target, input int budget, input string tag);
        int n = 0;
        while (!(m_run && m_count == target) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_reach"}, n < budget, 1);
    endtask

    task automatic launch(input logic cont, input int mi);
        continuous = cont;
        max_iter   = ITER_W'(mi);
        start      = 1'b1;
        cycle();
        start      = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        max_iter = '0; strobe_pos = {8'd98, 8'd28}; win_lo = 8'd90; win_hi = 8'd99;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        en = 1'b1;
        cycle();

        // Two bounded periods with strobes at 28/98 and window 90..98.
        done_seen = 0;
        launch(1'b0, 2);
        check("t1_busy_start", busy, 1);
        for (int k = 0; k < 230; k++) begin
            cycle();
            if (m_run && m_count == 29) check("t1_strobe0_at29", strobe[0], 1);
            if (m_run && m_count == 99) check("t1_strobe1_at99", strobe[1], 1);
            if (m_run && m_count == 89) check("t1_win_at89", window[0], 0);
            if (m_run && m_count == 90) check("t1_win_at90", window[0], 1);
            if (m_run && m_count == 98) check("t1_win_at98", window[0], 1);
            if (m_run && m_count == 99) check("t1_win_at99", window[0], 0);
        end
        check("t1_done_count", done_seen, 1);
        check("t1_iter", iter, 2);
        check("t1_busy_end", busy, 0);
        check("t1_idle_win", window, 0);

        // Stall for 5 cycles at count 27.
        launch(1'b0, 1);
        run_to_count(27, 200, "t3");
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t3_hold", count, 27);
            check("t3_nostrobe", strobe, 0);
        end
`ifdef IK_SEQ_STALL_MON_EN
        check("t3_stall5", stall_cycles, 5);
`endif
        en = 1'b1;
        cycle();
        check("t3_resume28", count, 28);
        cycle();
        check("t3_strobe0", strobe[0], 1);
        n = 0;
        while (m_run && n < 300) begin cycle(); n++; end
        check("t3_finish", busy, 0);

        // Continuous run ignores max_iter, then abort at count 50 of period 4.
        done_seen = 0;
        launch(1'b1, 1);
        n = 0;
        while (!(m_periods == 3 && m_count == 50) && n < 600) begin cycle(); n++; end
        check("t4_reach", n < 600, 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t4_count0", count, 0);
        check("t4_busy0", busy, 0);
        check("t4_iter3", iter, 3);
        check("t4_nodone", done_seen, 0);

        // max_iter 0 behaves as 1; start during RUN is ignored.
        done_seen = 0;
        launch(1'b0, 0);
        run_to_count(10, 50, "t5");
        start = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        start = 1'b0;
        check("t5_count13", count, 13);
        n = 0;
        while (m_run && n < 200) begin cycle(); n++; end
        check("t5_done_count", done_seen, 1);
        check("t5_iter1", iter, 1);

        // Asynchronous reset mid-run with the window active.
        win_lo = 8'd50; win_hi = 8'd70;
        launch(1'b1, 1);
        run_to_count(60, 200, "t6");
        check("t6_win_pre", window, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_count", count, 0);
        check("t6_busy", busy, 0);
        check("t6_iter", iter, 0);
        check("t6_window", window, 0);
        check("t6_strobe", strobe, 0);
        check("t6_done", done, 0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("t6_idle", busy, 0);

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            en    = ($urandom_range(7) != 0);
            start = ($urandom_range(19) == 0);
            abort = ($urandom_range(249) == 0);
            continuous = ($urandom_range(3) == 0);
            max_iter = ITER_W'($urandom_range(3));
            if ($urandom_range(299) == 0) begin
                strobe_pos = NS*CNT_W'($urandom_range(65535)) & 16'h7F7F;
                win_lo = CNT_W'($urandom_range(127));
                win_hi = CNT_W'($urandom_range(127));
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        failures++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
